// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: header layout, selector codes and loader state encoding
package cfg_loader_pkg;
  localparam int HDR_SEL_LSB = 28;
  localparam int HDR_SEL_W = 4;
  localparam int HDR_CNT_LSB = 16;
  localparam int HDR_CNT_W = 12;
  localparam int NUM_SEL = 9;
  localparam logic [HDR_SEL_W-1:0] SEL_LTP_LTD_WIN = 4'd0;
  localparam logic [HDR_SEL_W-1:0] SEL_LTP_LTD_RATE = 4'd1;
  localparam logic [HDR_SEL_W-1:0] SEL_BIAS_LEARN = 4'd2;
  localparam logic [HDR_SEL_W-1:0] SEL_NURN_TYPE = 4'd3;
  localparam logic [HDR_SEL_W-1:0] SEL_MASK_REST = 4'd4;
  localparam logic [HDR_SEL_W-1:0] SEL_AER = 4'd5;
  localparam logic [HDR_SEL_W-1:0] SEL_FIX_THR = 4'd6;
  localparam logic [HDR_SEL_W-1:0] SEL_LEARN_WEIGHT = 4'd7;
  localparam logic [HDR_SEL_W-1:0] SEL_NUM_NURN_AXON = 4'd8;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_UNPACK, ST_DRAIN} state_t;
  function automatic logic [NUM_SEL-1:0] sel_onehot(input logic [HDR_SEL_W-1:0] sel);
    logic [NUM_SEL-1:0] oh;
    oh = '0;
    case (sel)
      SEL_LTP_LTD_WIN:   oh[0] = 1'b1;
      SEL_LTP_LTD_RATE:  oh[1] = 1'b1;
      SEL_BIAS_LEARN:    oh[2] = 1'b1;
      SEL_NURN_TYPE:     oh[3] = 1'b1;
      SEL_MASK_REST:     oh[4] = 1'b1;
      SEL_AER:           oh[5] = 1'b1;
      SEL_FIX_THR:       oh[6] = 1'b1;
      SEL_LEARN_WEIGHT:  oh[7] = 1'b1;
      SEL_NUM_NURN_AXON: oh[8] = 1'b1;
      default:           oh = '0;
    endcase
    return oh;
  endfunction
  function automatic logic sel_valid(input logic [HDR_SEL_W-1:0] sel);
    return sel <= SEL_NUM_NURN_AXON;
  endfunction
endpackage

// File: rtl/cfg_stream_loader_if.sv
// cfg_stream_loader_if: config word stream in, config memory write port out
interface cfg_stream_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int WE_W = 9
);
  logic              cfg_valid_i;
  logic [31:0]       cfg_data_i;
  logic              cfg_ready_o;
  logic [DATA_W-1:0] config_data_out;
  logic [WE_W-1:0]   config_write_enable_out;
  logic [ADDR_W-1:0] config_write_address_out;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  modport master (
    output cfg_valid_i, cfg_data_i,
    input  cfg_ready_o, config_data_out, config_write_enable_out, config_write_address_out,
    input  busy_o, done_o, err_o
  );
  modport slave (
    input  cfg_valid_i, cfg_data_i,
    output cfg_ready_o, config_data_out, config_write_enable_out, config_write_address_out,
    output busy_o, done_o, err_o
  );
endinterface

// File: rtl/cfg_bit_unpacker.sv
// cfg_bit_unpacker: serialises bits 1..31 of a loaded word, bit 0 is written by the loader directly
module cfg_bit_unpacker (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_shift,
  output logic        o_bit,
  output logic        o_last
);
  logic [31:0] r_sr;
  logic [4:0]  r_cnt;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data >> 1;
      r_cnt <= 5'd1;
    end else if (i_shift) begin
      r_sr  <= r_sr >> 1;
      r_cnt <= r_cnt + 5'd1;
    end
  end
  assign o_bit  = r_sr[0];
  assign o_last = &r_cnt;
endmodule

// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: decodes config stream packets into config memory write strobes
module cfg_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_NURNS = 256,
  parameter int NUM_AXONS = 256,
  parameter int DSIZE = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int CONFIG_PARAMETER_NUMBER = 9,
  localparam int ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH
) (
  input logic clk_i,
  input logic rst_n_i,
  cfg_stream_loader_if.slave vif
);
  localparam int W_DATA = DSIZE * 2;
  localparam int unsigned NURN_LIM = NUM_NURNS;
  localparam int unsigned WGT_LIM = NUM_NURNS * NUM_AXONS;
  if (ADDR_W > 16) begin : g_addr_chk
    $error("ADDR_W must not exceed 16");
  end
  state_t                       r_state, w_state_nx;
  logic [HDR_SEL_W-1:0]         r_sel, w_sel_nx, w_hdr_sel;
  logic [HDR_CNT_W-1:0]         r_rem, w_rem_nx, w_hdr_cnt;
  logic [ADDR_W-1:0]            r_addr, w_addr_nx, r_waddr, w_waddr_nx;
  logic [W_DATA-1:0]            r_wdata, w_wdata_nx;
  logic [CONFIG_PARAMETER_NUMBER-1:0] r_we, w_we_nx, w_onehot;
  logic r_done, w_done_nx, r_err, w_err_nx;
  logic w_acc, w_ready, w_load, w_shift, w_bit, w_last;
  logic w_nurn_oob, w_wgt_oob, w_wr, w_rem_zero;
  cfg_bit_unpacker u_unpack (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_load  (w_load),
    .i_data  (vif.cfg_data_i),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );
  assign w_ready    = r_state != ST_UNPACK;
  assign w_acc      = vif.cfg_valid_i && w_ready;
  assign w_hdr_sel  = vif.cfg_data_i[HDR_SEL_LSB +: HDR_SEL_W];
  assign w_hdr_cnt  = vif.cfg_data_i[HDR_CNT_LSB +: HDR_CNT_W];
  assign w_onehot   = CONFIG_PARAMETER_NUMBER'(sel_onehot(r_sel));
  assign w_rem_zero = r_rem == '0;
  assign w_nurn_oob = (r_sel != SEL_NUM_NURN_AXON) && (32'(r_addr) >= NURN_LIM);
  assign w_wgt_oob  = 32'(r_addr) >= WGT_LIM;
  // the neuron/axon count lives at address 0 only; later words of that packet are swallowed
  assign w_wr       = (r_sel == SEL_NUM_NURN_AXON) ? (r_addr == '0) : !w_nurn_oob;
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_rem_nx   = r_rem;
    w_addr_nx  = r_addr;
    w_we_nx    = '0;
    w_waddr_nx = '0;
    w_wdata_nx = '0;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_acc) begin
        w_sel_nx   = w_hdr_sel;
        w_rem_nx   = w_hdr_cnt;
        w_addr_nx  = (w_hdr_sel == SEL_NUM_NURN_AXON) ? '0 : vif.cfg_data_i[ADDR_W-1:0];
        w_state_nx = sel_valid(w_hdr_sel) ? ST_DATA : ST_DRAIN;
        w_err_nx   = !sel_valid(w_hdr_sel);
      end
      ST_DATA: if (w_acc) begin
        w_addr_nx = r_addr + ADDR_W'(1);
        if (r_sel == SEL_LEARN_WEIGHT) begin
          w_load     = 1'b1;
          w_state_nx = ST_UNPACK;
          w_we_nx    = w_wgt_oob ? '0 : w_onehot;
          w_waddr_nx = r_addr;
          w_wdata_nx = W_DATA'(vif.cfg_data_i[0]);
          w_err_nx   = w_wgt_oob;
        end else begin
          w_we_nx    = w_wr ? w_onehot : '0;
          w_waddr_nx = w_wr ? r_addr : '0;
          w_wdata_nx = w_wr ? vif.cfg_data_i : '0;
          w_err_nx   = w_nurn_oob;
          w_done_nx  = w_rem_zero;
          w_rem_nx   = r_rem - HDR_CNT_W'(1);
          w_state_nx = w_rem_zero ? ST_IDLE : ST_DATA;
        end
      end
      ST_UNPACK: begin
        w_shift    = 1'b1;
        w_addr_nx  = r_addr + ADDR_W'(1);
        w_we_nx    = w_wgt_oob ? '0 : w_onehot;
        w_waddr_nx = r_addr;
        w_wdata_nx = W_DATA'(w_bit);
        w_err_nx   = w_wgt_oob;
        if (w_last) begin
          w_done_nx  = w_rem_zero;
          w_rem_nx   = r_rem - HDR_CNT_W'(1);
          w_state_nx = w_rem_zero ? ST_IDLE : ST_DATA;
        end
      end
      ST_DRAIN: if (w_acc) begin
        w_done_nx  = w_rem_zero;
        w_rem_nx   = r_rem - HDR_CNT_W'(1);
        w_state_nx = w_rem_zero ? ST_IDLE : ST_DRAIN;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_we    <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_rem   <= w_rem_nx;
      r_addr  <= w_addr_nx;
      r_we    <= w_we_nx;
      r_waddr <= w_waddr_nx;
      r_wdata <= w_wdata_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end
  assign vif.cfg_ready_o              = w_ready;
  assign vif.busy_o                   = r_state != ST_IDLE;
  assign vif.done_o                   = r_done;
  assign vif.err_o                    = r_err;
  assign vif.config_write_enable_out  = r_we;
  assign vif.config_write_address_out = r_waddr;
  assign vif.config_data_out          = r_wdata;
endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb_cfg_stream_loader: directed table, corner sequences and random packets against a packet-level model
module tb_cfg_stream_loader;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;
  cfg_stream_loader_if #(.DATA_W(32), .ADDR_W(16), .WE_W(9)) vif ();
  cfg_stream_loader dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .vif(vif));
  typedef struct packed {
    logic [8:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
    logic        done;
  } ev_t;
  typedef struct {
    logic [3:0]  sel;
    logic [15:0] a;
    logic [31:0] d;
    ev_t         exp;
  } vec_t;
  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  ev_t act_q[$];
  logic mon_en = 1'b0;
  logic [31:0] pkt_w[4];
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  function automatic ev_t ev(input logic [8:0] we, input logic [15:0] a, input logic [31:0] d,
                             input logic err, input logic done);
    return {we, a, d, err, done};
  endfunction
  function automatic ev_t cur();
    return {vif.config_write_enable_out, vif.config_write_address_out, vif.config_data_out,
            vif.err_o, vif.done_o};
  endfunction
  task automatic chk_ev(input string nm, input ev_t act, input ev_t exp);
    chk({nm, "_we"}, 64'(act.we), 64'(exp.we));
    chk({nm, "_err"}, 64'(act.err), 64'(exp.err));
    chk({nm, "_done"}, 64'(act.done), 64'(exp.done));
    if (exp.we != 9'd0) begin
      chk({nm, "_addr"}, 64'(act.addr), 64'(exp.addr));
      chk({nm, "_data"}, 64'(act.data), 64'(exp.data));
    end
  endtask
  function automatic logic [31:0] hdr(input logic [3:0] sel, input logic [11:0] cnt, input logic [15:0] a);
    return {sel, cnt, a};
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    vif.cfg_valid_i = 1'b1;
    vif.cfg_data_i = w;
    while (vif.cfg_ready_o !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%b want=1", vif.cfg_ready_o);
    end
    tick(1);
    vif.cfg_valid_i = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (vif.busy_o !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    chk({nm, "_idle"}, 64'(vif.busy_o), 64'd0);
  endtask
  // every write, error or done the loader should produce for one packet, in order
  function automatic void model(input int sel, input int cnt, input logic [15:0] a);
    logic [15:0] wa;
    logic oob;
    if (sel > 8) begin
      exp_q.push_back(ev(9'd0, 16'd0, 32'd0, 1'b1, 1'b0));
      exp_q.push_back(ev(9'd0, 16'd0, 32'd0, 1'b0, 1'b1));
      return;
    end
    for (int i = 0; i <= cnt; i++) begin
      if (sel == 7) begin
        for (int j = 0; j < 32; j++) begin
          wa = a + 16'(32 * i + j);
          exp_q.push_back(ev(9'h080, wa, (pkt_w[i] >> j) & 32'd1, 1'b0, i == cnt && j == 31));
        end
      end else if (sel == 8) begin
        if (i == 0) exp_q.push_back(ev(9'h100, 16'd0, pkt_w[i], 1'b0, cnt == 0));
        else if (i == cnt) exp_q.push_back(ev(9'd0, 16'd0, 32'd0, 1'b0, 1'b1));
      end else begin
        wa = a + 16'(i);
        oob = wa >= 16'd256;
        exp_q.push_back(ev(oob ? 9'd0 : 9'(1 << sel), wa, pkt_w[i], oob, i == cnt));
      end
    end
  endfunction
  always @(negedge clk_i)
    if (mon_en && (vif.config_write_enable_out != 9'd0 || vif.err_o || vif.done_o))
      act_q.push_back(cur());
  initial begin
    #2_000_000;
    $display("FAIL watchdog busy=%b want=0", vif.busy_o);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] ws[2];
    logic [31:0] bitv;
    int sel, cnt, ready_low;
    logic [15:0] a;
    tbl[0] = '{4'd0, 16'h0005, 32'h1234_5678, ev(9'h001, 16'h0005, 32'h1234_5678, 1'b0, 1'b1)};
    tbl[1] = '{4'd1, 16'h0080, 32'h0000_A5A5, ev(9'h002, 16'h0080, 32'h0000_A5A5, 1'b0, 1'b1)};
    tbl[2] = '{4'd2, 16'h0000, 32'hFFFF_FFFF, ev(9'h004, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b1)};
    tbl[3] = '{4'd3, 16'h00FF, 32'hDEAD_BEEF, ev(9'h008, 16'h00FF, 32'hDEAD_BEEF, 1'b0, 1'b1)};
    tbl[4] = '{4'd4, 16'h01FF, 32'h0000_0001, ev(9'h000, 16'h0000, 32'h0000_0000, 1'b1, 1'b1)};
    tbl[5] = '{4'd5, 16'h0100, 32'h0000_0002, ev(9'h000, 16'h0000, 32'h0000_0000, 1'b1, 1'b1)};
    tbl[6] = '{4'd6, 16'hFFFF, 32'h0000_0003, ev(9'h000, 16'h0000, 32'h0000_0000, 1'b1, 1'b1)};
    tbl[7] = '{4'd8, 16'h1234, 32'h0000_4020, ev(9'h100, 16'h0000, 32'h0000_4020, 1'b0, 1'b1)};
    tbl[8] = '{4'd7, 16'h0010, 32'h0000_0001, ev(9'h080, 16'h0010, 32'h0000_0001, 1'b0, 1'b0)};
    vif.cfg_valid_i = 1'b0;
    vif.cfg_data_i = '0;
    #1;
    chk_ev("reset", cur(), ev(9'd0, 16'd0, 32'd0, 1'b0, 1'b0));
    chk("reset_addr", 64'(vif.config_write_address_out), 64'd0);
    chk("reset_data", 64'(vif.config_data_out), 64'd0);
    chk("reset_ready", 64'(vif.cfg_ready_o), 64'd1);
    chk("reset_busy", 64'(vif.busy_o), 64'd0);
    tick(2);
    rst_n_i = 1'b1;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      send(hdr(tbl[i].sel, 12'd0, tbl[i].a));
      send(tbl[i].d);
      chk_ev($sformatf("tbl%0d", i), cur(), tbl[i].exp);
      wait_idle($sformatf("tbl%0d", i));
    end
    send(hdr(4'd6, 12'd2, 16'h0010));
    chk("seqA_busy", 64'(vif.busy_o), 64'd1);
    send(32'hA);
    chk_ev("seqA_w0", cur(), ev(9'h040, 16'h0010, 32'hA, 1'b0, 1'b0));
    send(32'hB);
    chk_ev("seqA_w1", cur(), ev(9'h040, 16'h0011, 32'hB, 1'b0, 1'b0));
    send(32'hC);
    chk_ev("seqA_w2", cur(), ev(9'h040, 16'h0012, 32'hC, 1'b0, 1'b1));
    tick(1);
    chk_ev("seqA_after", cur(), ev(9'd0, 16'd0, 32'd0, 1'b0, 1'b0));
    ws[0] = 32'h0000_0005;
    ws[1] = 32'hFFFF_FFFF;
    ready_low = 0;
    send(hdr(4'd7, 12'd1, 16'h00FE));
    send(ws[0]);
    vif.cfg_valid_i = 1'b1;
    vif.cfg_data_i = ws[1];
    for (int j = 0; j < 64; j++) begin
      if (j == 32) vif.cfg_valid_i = 1'b0;
      bitv = (ws[j / 32] >> (j % 32)) & 32'd1;
      chk_ev($sformatf("seqB_b%0d", j), cur(), ev(9'h080, 16'h00FE + 16'(j), bitv, 1'b0, j == 63));
      if (!vif.cfg_ready_o) ready_low++;
      tick(1);
    end
    chk("seqB_ready_low", 64'(ready_low), 64'd62);
    chk_ev("seqB_after", cur(), ev(9'd0, 16'd0, 32'd0, 1'b0, 1'b0));
    chk("seqB_busy", 64'(vif.busy_o), 64'd0);
    send(hdr(4'd0, 12'd1, 16'h00FF));
    send(32'h1111);
    chk_ev("seqC_w0", cur(), ev(9'h001, 16'h00FF, 32'h1111, 1'b0, 1'b0));
    send(32'h2222);
    chk_ev("seqC_w1", cur(), ev(9'h000, 16'h0000, 32'h0, 1'b1, 1'b1));
    tick(1);
    send(hdr(4'd12, 12'd3, 16'h0040));
    chk_ev("seqD_hdr", cur(), ev(9'h000, 16'h0000, 32'h0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + 32'(i));
      chk_ev($sformatf("seqD_w%0d", i), cur(), ev(9'h000, 16'h0000, 32'h0, 1'b0, i == 3));
    end
    chk("seqD_busy", 64'(vif.busy_o), 64'd0);
    chk("seqD_ready", 64'(vif.cfg_ready_o), 64'd1);
    send(hdr(4'd7, 12'd0, 16'h0020));
    send(32'hFFFF_FFFF);
    tick(9);
    chk_ev("seqF_bit9", cur(), ev(9'h080, 16'h0029, 32'h1, 1'b0, 1'b0));
    rst_n_i = 1'b0;
    #1;
    chk_ev("seqF_rst", cur(), ev(9'd0, 16'd0, 32'd0, 1'b0, 1'b0));
    chk("seqF_rst_addr", 64'(vif.config_write_address_out), 64'd0);
    chk("seqF_rst_data", 64'(vif.config_data_out), 64'd0);
    chk("seqF_rst_ready", 64'(vif.cfg_ready_o), 64'd1);
    chk("seqF_rst_busy", 64'(vif.busy_o), 64'd0);
    tick(1);
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("seqF_quiet%0d", i), 64'(vif.config_write_enable_out), 64'd0);
    end
    send(hdr(4'd1, 12'd0, 16'h0003));
    send(32'h0000_CAFE);
    chk_ev("seqF_next", cur(), ev(9'h002, 16'h0003, 32'h0000_CAFE, 1'b0, 1'b1));
    tick(2);
    mon_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      sel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      cnt = (sel == 7) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: a = 16'($urandom);
        1: a = 16'($urandom_range(240, 270));
        default: a = 16'($urandom_range(65500, 65535));
      endcase
      for (int i = 0; i <= cnt; i++) pkt_w[i] = $urandom;
      model(sel, cnt, a);
      send(hdr(4'(sel), 12'(cnt), a));
      for (int i = 0; i <= cnt; i++) begin
        tick($urandom_range(0, 2));
        send(pkt_w[i]);
      end
    end
    wait_idle("rand");
    tick(3);
    mon_en = 1'b0;
    chk("rand_events", 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk_ev($sformatf("rand_ev%0d", i), act_q[i], exp_q[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
